adc_scan_serial_tx: RTL and testbench

- Parametrised successor of the ITC99-style channel-scan/serial-link block.
- Steps an external analog mux across NUM_CH channels and runs the ADC soc/eoc handshake per channel.
- Captures each DATA_W-bit sample and sends it over a UART-like serial line, paced by dsr.
- Adds over the previous generation: configurable width, channel count and bit time; optional channel-tag word; optional even parity; configurable stop bits; synchronous reset.

---
 rtl/adc_scan_pkg.sv | 40 ++++
 rtl/adc_scan_serial_tx_core.sv | 190 +++++++++++++++++++
 rtl/adc_scan_serial_tx.sv | 168 ++++++++++++++++
 tb/tb_adc_scan_serial_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared definitions for the channel-scan / serial-link block.
//   scan_state_t : channel-scan FSM encodings
//   tx_state_t   : serial transmitter FSM encodings
//   clog2()      : ceiling log2, usable in localparam expressions
package adc_scan_pkg;

    typedef enum logic [3:0] {
        SC_MUX    = 4'd0,
        SC_SETTLE = 4'd1,
        SC_SOC    = 4'd2,
        SC_WAIT   = 4'd3,
        SC_NEXT   = 4'd4,
        SC_TAG    = 4'd5,
        SC_TAGW   = 4'd6,
        SC_DATA   = 4'd7,
        SC_DATAW  = 4'd8
    } scan_state_t;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_WAITDSR = 3'd1,
        TX_START   = 3'd2,
        TX_DATA    = 3'd3,
        TX_PAR     = 3'd4,
        TX_STOP    = 3'd5
    } tx_state_t;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_scan_serial_tx_core.sv
// UART-like frame transmitter with dsr gating.
// Frame: start(0), DATA_W bits MSB first, optional even parity, STOP_BITS ones,
// every symbol held BIT_DELAY clocks.
//
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   tx_req         : request to send tx_word (held by requester until accepted)
//   tx_word        : word to send, latched on accept
//   dsr            : receiver ready; only consulted before the frame starts
//   tx_accept      : request taken this cycle (idle and tx_req)
//   tx_done        : one-cycle pulse on the last cycle of the final stop symbol
//   data_out       : serial line, idles high
//   error          : set while a request waits on dsr=0, cleared at frame start
//   busy           : a frame is pending or being shifted
//
// state      | meaning
// -----------+--------------------------------------------
// TX_IDLE    | line high, waiting for tx_req
// TX_WAITDSR | word latched, receiver not ready (error set)
// TX_START   | start symbol (0)
// TX_DATA    | data bits, MSB first, sym_idx counts bits
// TX_PAR     | even parity symbol
// TX_STOP    | stop symbols, sym_idx counts stop symbols
module serial_tx_core
    import adc_scan_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BIT_DELAY = 104,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tx_req,
    input  logic [DATA_W-1:0] tx_word,
    input  logic              dsr,
    output logic              tx_accept,
    output logic              tx_done,
    output logic              data_out,
    output logic              error,
    output logic              busy
);

    localparam int CNT_W = (clog2(BIT_DELAY) < 1) ? 1 : clog2(BIT_DELAY);
    localparam int IDX_W = clog2(DATA_W + 4);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIT_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t         state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  sym_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;
    logic              bit_tc;
    logic              load_word, load_cnt, shift_en, idx_clr, idx_inc, err_set, err_clr;

    assign bit_tc = (bit_cnt == '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_word  = 1'b0;
        load_cnt   = 1'b0;
        shift_en   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            TX_IDLE: begin
                if (tx_req) begin
                    load_word = 1'b1;
                    if (dsr) begin
                        state_next = TX_START;
                        load_cnt   = 1'b1;
                        err_clr    = 1'b1;
                    end else begin
                        state_next = TX_WAITDSR;
                        err_set    = 1'b1;
                    end
                end
            end
            TX_WAITDSR: begin
                if (dsr) begin
                    state_next = TX_START;
                    load_cnt   = 1'b1;
                    err_clr    = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            TX_START: begin
                if (bit_tc) begin
                    state_next = TX_DATA;
                    load_cnt   = 1'b1;
                    idx_clr    = 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_tc) begin
                    load_cnt = 1'b1;
                    if (sym_idx == LAST_DATA) begin
                        idx_clr    = 1'b1;
                        state_next = (PARITY_EN != 0) ? TX_PAR : TX_STOP;
                    end else begin
                        idx_inc  = 1'b1;
                        shift_en = 1'b1;
                    end
                end
            end
            TX_PAR: begin
                if (bit_tc) begin
                    state_next = TX_STOP;
                    load_cnt   = 1'b1;
                    idx_clr    = 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_tc) begin
                    if (sym_idx == LAST_STOP) begin
                        state_next = TX_IDLE;
                    end else begin
                        load_cnt = 1'b1;
                        idx_inc  = 1'b1;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Bit-time down-counter parks at zero outside a frame, so it never wraps.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            sym_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (load_cnt) begin
                bit_cnt <= CNT_LOAD;
            end else if (!bit_tc) begin
                bit_cnt <= bit_cnt - 1'b1;
            end

            if (idx_clr) begin
                sym_idx <= '0;
            end else if (idx_inc) begin
                sym_idx <= sym_idx + 1'b1;
            end

            if (load_word) begin
                shift_reg  <= tx_word;
                parity_bit <= ^tx_word;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            end

            if (err_set) begin
                error <= 1'b1;
            end else if (err_clr) begin
                error <= 1'b0;
            end
        end
    end

    assign tx_accept = (state == TX_IDLE) && tx_req;
    assign tx_done   = (state == TX_STOP) && bit_tc && (sym_idx == LAST_STOP);
    assign busy      = (state != TX_IDLE);

    always_comb begin
        data_out = 1'b1;
        case (state)
            TX_START: data_out = 1'b0;
            TX_DATA:  data_out = shift_reg[DATA_W-1];
            TX_PAR:   data_out = parity_bit;
            default:  data_out = 1'b1;
        endcase
    end

endmodule

// File: rtl/adc_scan_serial_tx.sv
// Channel scanner: steps an analog mux over NUM_CH channels, runs the ADC
// soc/eoc handshake, captures each sample and ships it (optionally preceded
// by a channel-tag frame) through serial_tx_core.
//
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   eoc            : ADC end of conversion, active low
//   data_in        : ADC result
//   dsr            : receiver ready
//   soc            : ADC start of conversion
//   load_dato      : one-cycle pulse while the captured sample is fresh
//   mux_en         : analog mux enable
//   canale         : channel being converted
//   data_out       : serial line
//   error          : dsr error, cleared at frame start
//   busy           : transmitter busy
//
// state     | meaning
// ----------+---------------------------------------------------
// SC_MUX    | enable mux on current channel
// SC_SETTLE | one cycle of mux settling
// SC_SOC    | raise soc
// SC_WAIT   | wait for eoc low, then capture data_in
// SC_NEXT   | drop soc and load_dato
// SC_TAG    | request tag frame (channel number)
// SC_TAGW   | wait for tag frame to finish
// SC_DATA   | request sample frame
// SC_DATAW  | wait for sample frame, then advance channel
module adc_scan_serial_tx
    import adc_scan_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 8,
    parameter int BIT_DELAY = 104,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1,
    parameter int TAG_EN    = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 eoc,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 dsr,
    output logic                 soc,
    output logic                 load_dato,
    output logic                 mux_en,
    output logic [((clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH))-1:0] canale,
    output logic                 data_out,
    output logic                 error,
    output logic                 busy
);

    localparam int CH_W = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    scan_state_t       state, state_next;
    logic [DATA_W-1:0] hold_reg;
    logic              soc_next, mux_en_next, load_next;
    logic              hold_en, ch_adv;
    logic              tx_req, tx_accept, tx_done;
    logic [DATA_W-1:0] tx_word;

    // Request and word depend on scan state only, keeping the accept path acyclic.
    assign tx_req  = (state == SC_TAG) || (state == SC_DATA);
    assign tx_word = (state == SC_TAG) ? DATA_W'(canale) : hold_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= SC_MUX;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        soc_next    = soc;
        mux_en_next = mux_en;
        load_next   = load_dato;
        hold_en     = 1'b0;
        ch_adv      = 1'b0;
        case (state)
            SC_MUX: begin
                mux_en_next = 1'b1;
                state_next  = SC_SETTLE;
            end
            SC_SETTLE: state_next = SC_SOC;
            SC_SOC: begin
                soc_next   = 1'b1;
                state_next = SC_WAIT;
            end
            SC_WAIT: begin
                if (!eoc) begin
                    load_next   = 1'b1;
                    mux_en_next = 1'b0;
                    hold_en     = 1'b1;
                    state_next  = SC_NEXT;
                end
            end
            SC_NEXT: begin
                soc_next   = 1'b0;
                load_next  = 1'b0;
                state_next = (TAG_EN != 0) ? SC_TAG : SC_DATA;
            end
            SC_TAG: begin
                if (tx_accept) begin
                    state_next = SC_TAGW;
                end
            end
            SC_TAGW: begin
                if (tx_done) begin
                    state_next = SC_DATA;
                end
            end
            SC_DATA: begin
                if (tx_accept) begin
                    state_next = SC_DATAW;
                end
            end
            SC_DATAW: begin
                if (tx_done) begin
                    ch_adv     = 1'b1;
                    state_next = SC_MUX;
                end
            end
            default: state_next = SC_MUX;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            soc       <= 1'b0;
            mux_en    <= 1'b0;
            load_dato <= 1'b0;
            hold_reg  <= '0;
            canale    <= '0;
        end else begin
            soc       <= soc_next;
            mux_en    <= mux_en_next;
            load_dato <= load_next;
            if (hold_en) begin
                hold_reg <= data_in;
            end
            if (ch_adv) begin
                canale <= (canale == CH_LAST) ? '0 : canale + 1'b1;
            end
        end
    end

    serial_tx_core #(
        .DATA_W    (DATA_W),
        .BIT_DELAY (BIT_DELAY),
        .PARITY_EN (PARITY_EN),
        .STOP_BITS (STOP_BITS)
    ) u_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .tx_req    (tx_req),
        .tx_word   (tx_word),
        .dsr       (dsr),
        .tx_accept (tx_accept),
        .tx_done   (tx_done),
        .data_out  (data_out),
        .error     (error),
        .busy      (busy)
    );

endmodule

// File: tb/tb_adc_scan_serial_tx.sv
module tb_adc_scan_serial_tx;

    logic clk;
    int   passed;
    int   total;
    int   n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: BIT_DELAY=4, defaults otherwise
    logic       ra, eoca, dsra, soca, loada, muxa, douta, erra, busya;
    logic [7:0] da;
    logic [2:0] cha;
    // Instance B: NUM_CH=3 wrap
    logic       rb, eocb, dsrb, socb, loadb, muxb, doutb, errb, busyb;
    logic [7:0] db;
    logic [1:0] chb;
    // Instance C: parity + two stop bits
    logic       rc, eocc, dsrc, socc, loadc, muxc, doutc, errc, busyc;
    logic [7:0] dc;
    logic [2:0] chc;
    // Instance D: tag mode
    logic       rd, eocd, dsrd, socd, loadd, muxd, doutd, errd, busyd;
    logic [7:0] dd;
    logic [2:0] chd;

    adc_scan_serial_tx #(.BIT_DELAY(4)) dut_a (
        .clock(clk), .reset_n(ra), .eoc(eoca), .data_in(da), .dsr(dsra),
        .soc(soca), .load_dato(loada), .mux_en(muxa), .canale(cha),
        .data_out(douta), .error(erra), .busy(busya));

    adc_scan_serial_tx #(.NUM_CH(3), .BIT_DELAY(2)) dut_b (
        .clock(clk), .reset_n(rb), .eoc(eocb), .data_in(db), .dsr(dsrb),
        .soc(socb), .load_dato(loadb), .mux_en(muxb), .canale(chb),
        .data_out(doutb), .error(errb), .busy(busyb));

    adc_scan_serial_tx #(.BIT_DELAY(4), .PARITY_EN(1), .STOP_BITS(2)) dut_c (
        .clock(clk), .reset_n(rc), .eoc(eocc), .data_in(dc), .dsr(dsrc),
        .soc(socc), .load_dato(loadc), .mux_en(muxc), .canale(chc),
        .data_out(doutc), .error(errc), .busy(busyc));

    adc_scan_serial_tx #(.BIT_DELAY(2), .TAG_EN(1)) dut_d (
        .clock(clk), .reset_n(rd), .eoc(eocd), .data_in(dd), .dsr(dsrd),
        .soc(socd), .load_dato(loadd), .mux_en(muxd), .canale(chd),
        .data_out(doutd), .error(errd), .busy(busyd));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [9:0]  pat_a;
    logic [11:0] pat_c;
    logic [9:0]  pat_tag;
    logic [9:0]  pat_dat;
    int          exp_scan  [4];
    int          exp_after [4];

    initial begin
        passed = 0;
        total  = 0;
        pat_a   = 10'b0_10100101_1;
        pat_c   = 12'b0_00000111_1_11;
        pat_tag = 10'b0_00000101_1;
        pat_dat = 10'b0_00111100_1;
        exp_scan  = '{0, 1, 2, 0};
        exp_after = '{1, 2, 0, 1};

        ra = 1'b0; eoca = 1'b1; dsra = 1'b1; da = 8'hA5;
        rb = 1'b0; eocb = 1'b0; dsrb = 1'b1; db = 8'h5A;
        rc = 1'b0; eocc = 1'b0; dsrc = 1'b1; dc = 8'h07;
        rd = 1'b0; eocd = 1'b0; dsrd = 1'b1; dd = 8'h3C;

        // ---- A: reset and first scan ----
        repeat (3) tick();
        check1("a_rst_soc", soca, 1'b0);
        check1("a_rst_load", loada, 1'b0);
        check1("a_rst_mux", muxa, 1'b0);
        check8("a_rst_canale", 8'(cha), 8'd0);
        check1("a_rst_dout", douta, 1'b1);
        check1("a_rst_err", erra, 1'b0);
        check1("a_rst_busy", busya, 1'b0);

        ra = 1'b1;
        tick();
        check1("a_mux_on", muxa, 1'b1);
        check1("a_soc_e0", soca, 1'b0);
        tick();
        check1("a_soc_e1", soca, 1'b0);
        tick();
        check1("a_soc_rise", soca, 1'b1);
        repeat (2) tick();
        check1("a_wait_noload", loada, 1'b0);
        eoca = 1'b0;
        tick();
        check1("a_load_pulse", loada, 1'b1);
        check1("a_mux_off", muxa, 1'b0);
        eoca = 1'b1;
        tick();
        check1("a_load_single", loada, 1'b0);
        check1("a_soc_fall", soca, 1'b0);
        tick();
        check1("a_busy_start", busya, 1'b1);
        for (int i = 0; i < 40; i++) begin
            check1("a_frame_bit", douta, pat_a[9 - (i / 4)]);
            tick();
        end
        check1("a_busy_end", busya, 1'b0);
        check8("a_canale_next", 8'(cha), 8'd1);

        // ---- A: dsr gating ----
        dsra = 1'b0;
        eoca = 1'b0;
        repeat (4) tick();
        check1("g_load", loada, 1'b1);
        repeat (2) tick();
        check1("g_err_set", erra, 1'b1);
        check1("g_busy", busya, 1'b1);
        check1("g_dout_idle", douta, 1'b1);
        eoca = 1'b1;
        repeat (3) tick();
        check1("g_err_sticky", erra, 1'b1);
        check1("g_dout_hold", douta, 1'b1);
        dsra = 1'b1;
        tick();
        check1("g_start", douta, 1'b0);
        check1("g_err_clr", erra, 1'b0);

        // ---- A: reset during data bit 3 ----
        repeat (17) tick();
        check1("r_bit3", douta, 1'b0);
        check1("r_busy_mid", busya, 1'b1);
        ra = 1'b0;
        tick();
        check1("r_dout", douta, 1'b1);
        check1("r_busy", busya, 1'b0);
        check8("r_canale", 8'(cha), 8'd0);
        ra = 1'b1;
        tick();
        check1("r_mux_restart", muxa, 1'b1);
        check8("r_canale_restart", 8'(cha), 8'd0);
        ra = 1'b0;

        // ---- B: channel wrap ----
        rb = 1'b1;
        for (int s = 0; s < 4; s++) begin
            n = 0;
            while (loadb !== 1'b1 && n < 200) begin tick(); n++; end
            check1("b_load_seen", n < 200, 1'b1);
            check8("b_canale_scan", 8'(chb), 8'(exp_scan[s]));
            n = 0;
            while (busyb !== 1'b1 && n < 200) begin tick(); n++; end
            check1("b_busy_rise", n < 200, 1'b1);
            n = 0;
            while (busyb === 1'b1 && n < 200) begin tick(); n++; end
            check1("b_busy_fall", n < 200, 1'b1);
            check8("b_canale_after", 8'(chb), 8'(exp_after[s]));
            check1("b_never3", chb != 2'd3, 1'b1);
        end
        rb = 1'b0;

        // ---- C: parity and two stop bits ----
        rc = 1'b1;
        n = 0;
        while (busyc !== 1'b1 && n < 200) begin tick(); n++; end
        check1("c_busy_rise", n < 200, 1'b1);
        for (int i = 0; i < 48; i++) begin
            if (i % 4 == 1) check1("c_frame_sym", doutc, pat_c[11 - (i / 4)]);
            if (i == 47) check1("c_busy_last", busyc, 1'b1);
            tick();
        end
        check1("c_frame_len", busyc, 1'b0);
        rc = 1'b0;

        // ---- D: tag mode on channel 5 ----
        rd = 1'b1;
        n = 0;
        while (chd !== 3'd5 && n < 2000) begin tick(); n++; end
        check1("d_reach_ch5", n < 2000, 1'b1);
        n = 0;
        while (busyd !== 1'b1 && n < 200) begin tick(); n++; end
        check1("d_busy_rise", n < 200, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) check1("d_tag_sym", doutd, pat_tag[9 - (i / 2)]);
            tick();
        end
        check1("d_gap_dout", doutd, 1'b1);
        check1("d_gap_busy", busyd, 1'b0);
        tick();
        check1("d_data_start", doutd, 1'b0);
        check1("d_data_busy", busyd, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) check1("d_data_sym", doutd, pat_dat[9 - (i / 2)]);
            tick();
        end
        check1("d_data_end", busyd, 1'b0);
        rd = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
